// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one word-aligned instruction-memory read at
// a time and buffers up to four returned {pc, instruction} pairs for decode.
// A redirect flushes the buffer and re-steers fetch; a response that was
// already in flight when the redirect hit is absorbed and thrown away.
`timescale 1ns/1ps
module fetch_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DISCARD
    } state_t;

    state_t      state_q;
    logic [2:0]  count_q;
    logic [2:0]  count_d;
    logic [1:0]  rdPtr_q;
    logic [1:0]  wrPtr_q;
    logic [31:0] fetchPc_q;
    logic [31:0] addr_q;
    logic [31:0] pcMem_q   [0:3];
    logic [31:0] instMem_q [0:3];

    logic        push;
    logic        pop;
    logic [31:0] redirectTarget;

    // Decide this cycle's push/pop and the resulting occupancy; a redirect
    // suppresses both so the flush wins over any queue movement.
    always_comb begin
        redirectTarget = redirect_pc & ~32'h0000_0003;
        pop            = (count_q != 3'd0) && !stall && !redirect;
        push           = (state_q == WAIT) && imem_ack && !redirect;
        count_d        = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Fetch control FSM plus queue bookkeeping; the request address is held
    // steady while a request is pending so memory sees a stable address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 3'd0;
            rdPtr_q   <= 2'd0;
            wrPtr_q   <= 2'd0;
            fetchPc_q <= 32'd96;
            addr_q    <= 32'd0;
        end else if (redirect) begin
            count_q   <= 3'd0;
            rdPtr_q   <= 2'd0;
            wrPtr_q   <= 2'd0;
            fetchPc_q <= redirectTarget;
            if (state_q != IDLE) begin
                state_q <= imem_ack ? IDLE : WAIT_DISCARD;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            if (push) begin
                wrPtr_q <= wrPtr_q + 2'd1;
            end
            case (state_q)
                IDLE: begin
                    if (count_q < 3'd4) begin
                        state_q <= WAIT;
                        addr_q  <= fetchPc_q;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        fetchPc_q <= addr_q + 32'd4;
                        if (count_d < 3'd4) begin
                            addr_q <= addr_q + 32'd4;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_DISCARD: begin
                    if (imem_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pcMem_q[wrPtr_q]   <= addr_q;
            instMem_q[wrPtr_q] <= imem_data;
        end
    end

    // Present the head entry; an empty queue shows zeros so stale data never
    // leaks toward decode.
    always_comb begin
        inst_valid = (count_q != 3'd0);
        inst       = inst_valid ? instMem_q[rdPtr_q] : 32'h0000_0000;
        inst_pc    = inst_valid ? pcMem_q[rdPtr_q]   : 32'h0000_0000;
        imem_req   = (state_q != IDLE);
        imem_addr  = addr_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: a simple memory model answers with a
// word derived from the address, and each scenario checks hand-computed
// addresses and queue-head values one cycle at a time.
`timescale 1ns/1ps
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address, easy to predict.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_data = memWord(imem_addr);

    // Hold reset for two cycles with quiet inputs, release it at a negedge.
    task automatic doReset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4000;
        imem_ack    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++;
        if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++;
        if (inst !== 32'd0 || inst_pc !== 32'd0) begin errors++; $display("FAIL reset_head: got inst %h pc %h expected 0 0", inst, inst_pc); end
        reset    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd96) begin errors++; $display("FAIL reset_first_req: got req %b addr %h expected 1 00000060", imem_req, imem_addr); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_first_valid: got %b expected 0", inst_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] expAddr;
        logic [31:0] expPc;
        doReset();
        imem_ack = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            expAddr = 32'd96 + 32'(4 * (k - 1));
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== expAddr) begin errors++; $display("FAIL stream_addr[%0d]: got req %b addr %h expected 1 %h", k, imem_req, imem_addr, expAddr); end
            if (k == 1) begin
                checks++;
                if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_nobypass: got valid %b expected 0", inst_valid); end
            end else begin
                expPc = 32'd96 + 32'(4 * (k - 2));
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== expPc || inst !== memWord(expPc)) begin
                    errors++;
                    $display("FAIL stream_head[%0d]: got v %b pc %h inst %h expected 1 %h %h", k, inst_valid, inst_pc, inst, expPc, memWord(expPc));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] expPc;
        doReset();
        stall    = 1'b1;
        imem_ack = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
        end
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b expected 0", imem_req); end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd96 || inst !== memWord(32'd96)) begin
            errors++;
            $display("FAIL stall_hold_head: got v %b pc %h inst %h expected 1 00000060 %h", inst_valid, inst_pc, inst, memWord(32'd96));
        end
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expPc = 32'd100 + 32'(4 * k);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== expPc || inst !== memWord(expPc)) begin
                errors++;
                $display("FAIL stall_release_order[%0d]: got v %b pc %h inst %h expected 1 %h %h", k, inst_valid, inst_pc, inst, expPc, memWord(expPc));
            end
            if (k == 0) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_release_req0: got %b expected 0", imem_req); end
            end
            if (k == 1) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'd112) begin errors++; $display("FAIL stall_refetch: got req %b addr %h expected 1 00000070", imem_req, imem_addr); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        doReset();
        stall    = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || imem_addr !== 32'd104) begin errors++; $display("FAIL redir_setup: got v %b addr %h expected 1 00000068", inst_valid, imem_addr); end
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid %b expected 0", inst_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd104) begin errors++; $display("FAIL redir_hold_addr: got req %b addr %h expected 1 00000068", imem_req, imem_addr); end
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_discard: got req %b valid %b expected 0 0", imem_req, inst_valid); end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: got req %b addr %h valid %b expected 1 00000200 0", imem_req, imem_addr, inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0200 || inst !== memWord(32'h200)) begin
            errors++;
            $display("FAIL redir_first_head: got v %b pc %h inst %h expected 1 00000200 %h", inst_valid, inst_pc, inst, memWord(32'h200));
        end
    endtask

    task automatic test_redirect_ack();
        doReset();
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1000;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redack_flush: got req %b valid %b expected 0 0", imem_req, inst_valid); end
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL redack_target: got req %b addr %h expected 1 00001000", imem_req, imem_addr); end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_1000 || inst !== memWord(32'h1000)) begin
            errors++;
            $display("FAIL redack_head: got v %b pc %h inst %h expected 1 00001000 %h", inst_valid, inst_pc, inst, memWord(32'h1000));
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        stall    = 1'b1;
        imem_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd108 || inst_pc !== 32'd96) begin
            errors++;
            $display("FAIL rstmid_setup: got req %b addr %h pc %h expected 1 0000006c 00000060", imem_req, imem_addr, inst_pc);
        end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got req %b addr %h v %b inst %h pc %h expected all 0", imem_req, imem_addr, inst_valid, inst, inst_pc);
        end
        reset    = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd96 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart: got req %b addr %h v %b expected 1 00000060 0", imem_req, imem_addr, inst_valid);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd96) begin errors++; $display("FAIL rstmid_head: got v %b pc %h expected 1 00000060", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        doReset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle: got req %b expected 0", imem_req); end
        redirect = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req %b addr %h expected 1 fffffffc", imem_req, imem_addr); end
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0000_0000 || inst_pc !== 32'hFFFF_FFFC || inst !== memWord(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_second: got addr %h pc %h inst %h expected 00000000 fffffffc %h", imem_addr, inst_pc, inst, memWord(32'hFFFF_FFFC));
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0000_0004 || inst_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_third: got addr %h pc %h expected 00000004 00000000", imem_addr, inst_pc); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
